// File: rtl/riscv32ima_pkg.sv
// Shared types for the riscv32ima instruction/data memory arbiter.
// The request struct widths are the widest the arbiter carries; the top narrows them to its parameters.
package riscv32ima_pkg;

    localparam int REQ_AW = 32;
    localparam int REQ_DW = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic              ncs;
        logic              nwe;
        logic [REQ_AW-1:0] addr;
        logic [REQ_DW-1:0] wdata;
        logic [REQ_DW-1:0] wmask;
    } req_t;

    localparam req_t REQ_NONE = '{ncs: 1'b1, nwe: 1'b1, addr: '0, wdata: '0, wmask: '0};

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/riscv32ima_arb_pick.sv
// Combinational grant selector: d-priority with a fetch starvation bound, or round-robin under RISCV32IMA_ARB_RR_EN.
// Zero latency; no backpressure of its own, the top freezes the grant while memory stalls.
module riscv32ima_arb_pick
    import riscv32ima_pkg::*;
#(
    parameter int MAX_WAIT = 7,
    parameter int WAIT_W   = cnt_width(MAX_WAIT)
) (
    input  logic              i_req,
    input  logic              d_req,
`ifdef RISCV32IMA_ARB_RR_EN
    input  owner_t            last_grant,
`else
    input  logic [WAIT_W-1:0] wait_cnt,
`endif
    output logic              gnt_vld,
    output owner_t            gnt_own
);

    always_comb begin
        gnt_vld = i_req | d_req;
        gnt_own = OWN_I;
`ifdef RISCV32IMA_ARB_RR_EN
        if (i_req && d_req) begin
            gnt_own = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (d_req) begin
            gnt_own = OWN_D;
        end
`else
        // A fetch that has lost MAX_WAIT times in a row is forced through.
        if (d_req && !(i_req && (wait_cnt == WAIT_W'(MAX_WAIT)))) begin
            gnt_own = OWN_D;
        end
`endif
    end

endmodule

// File: rtl/riscv32ima_mem_arb.sv
// Shares one single-ported memory between fetch (i_*) and data (d_*) ports; RISCV32IMA_ARB_RR_EN selects round-robin.
// Zero added request latency, read data routed one cycle after accept; grant frozen while m_stall, loser sees stall=1.
module riscv32ima_mem_arb
    import riscv32ima_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_WAIT   = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_ncs,
    input  logic                  i_nwe,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [DATA_WIDTH-1:0] i_wmask,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_stall,
    input  logic                  d_ncs,
    input  logic                  d_nwe,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [DATA_WIDTH-1:0] d_wmask,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_stall,
    output logic                  m_ncs,
    output logic                  m_nwe,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [DATA_WIDTH-1:0] m_wmask,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_stall
);

    localparam int WAIT_W = cnt_width(MAX_WAIT);

    arb_state_t state_q, state_d;
    owner_t     rsp_owner_q, rsp_owner_d;
    logic       rsp_rd_q, rsp_rd_d;

    logic   i_req, d_req;
    logic   pick_vld, gnt_vld, accept;
    owner_t pick_own, gnt_own;
    req_t   i_rq, d_rq, m_rq;

    assign i_req = ~i_ncs;
    assign d_req = ~d_ncs;

`ifdef RISCV32IMA_ARB_RR_EN
    owner_t last_grant_q, last_grant_d;
`else
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

    riscv32ima_arb_pick #(
        .MAX_WAIT (MAX_WAIT),
        .WAIT_W   (WAIT_W)
    ) u_pick (
        .i_req      (i_req),
        .d_req      (d_req),
`ifdef RISCV32IMA_ARB_RR_EN
        .last_grant (last_grant_q),
`else
        .wait_cnt   (wait_cnt_q),
`endif
        .gnt_vld    (pick_vld),
        .gnt_own    (pick_own)
    );

    always_comb begin
        gnt_vld = 1'b0;
        gnt_own = OWN_I;
        case (state_q)
            IDLE: begin
                gnt_vld = pick_vld;
                gnt_own = pick_own;
            end
            HOLD_I: begin
                gnt_vld = 1'b1;
                gnt_own = OWN_I;
            end
            HOLD_D: begin
                gnt_vld = 1'b1;
                gnt_own = OWN_D;
            end
            default: begin
                gnt_vld = 1'b0;
                gnt_own = OWN_I;
            end
        endcase
        state_d = IDLE;
        if (gnt_vld && m_stall) begin
            state_d = (gnt_own == OWN_I) ? HOLD_I : HOLD_D;
        end
    end

    always_comb begin
        i_rq = '{ncs: i_ncs, nwe: i_nwe, addr: REQ_AW'(i_addr),
                 wdata: REQ_DW'(i_wdata), wmask: REQ_DW'(i_wmask)};
        d_rq = '{ncs: d_ncs, nwe: d_nwe, addr: REQ_AW'(d_addr),
                 wdata: REQ_DW'(d_wdata), wmask: REQ_DW'(d_wmask)};
        m_rq = REQ_NONE;
        if (gnt_vld) begin
            m_rq = (gnt_own == OWN_I) ? i_rq : d_rq;
        end
    end

    assign m_ncs   = m_rq.ncs;
    assign m_nwe   = m_rq.nwe;
    assign m_addr  = m_rq.addr[ADDR_WIDTH-1:0];
    assign m_wdata = m_rq.wdata[DATA_WIDTH-1:0];
    assign m_wmask = m_rq.wmask[DATA_WIDTH-1:0];

    assign accept  = gnt_vld & ~m_stall;
    // A requester is released only when it holds the grant and memory takes it.
    assign i_stall = i_req & ~(gnt_vld && (gnt_own == OWN_I) && !m_stall);
    assign d_stall = d_req & ~(gnt_vld && (gnt_own == OWN_D) && !m_stall);

    always_comb begin
        rsp_rd_d    = accept & m_rq.nwe;
        rsp_owner_d = gnt_own;
    end

    assign i_rdata = (rsp_rd_q && (rsp_owner_q == OWN_I)) ? m_rdata : '0;
    assign d_rdata = (rsp_rd_q && (rsp_owner_q == OWN_D)) ? m_rdata : '0;

`ifdef RISCV32IMA_ARB_RR_EN
    always_comb begin
        last_grant_d = accept ? gnt_own : last_grant_q;
    end
`else
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (i_ncs || (accept && (gnt_own == OWN_I))) begin
            wait_cnt_d = '0;
        end else if (gnt_vld && (gnt_own == OWN_D) && (wait_cnt_q != WAIT_W'(MAX_WAIT))) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rsp_rd_q     <= 1'b0;
            rsp_owner_q  <= OWN_I;
`ifdef RISCV32IMA_ARB_RR_EN
            last_grant_q <= OWN_I;
`else
            wait_cnt_q   <= '0;
`endif
        end else begin
            state_q      <= state_d;
            rsp_rd_q     <= rsp_rd_d;
            rsp_owner_q  <= rsp_owner_d;
`ifdef RISCV32IMA_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            wait_cnt_q   <= wait_cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_riscv32ima_mem_arb.sv
// Directed bench for riscv32ima_mem_arb; the round-robin sequence runs when RISCV32IMA_ARB_RR_EN is defined.
module tb_riscv32ima_mem_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_ncs, i_nwe, d_ncs, d_nwe;
    logic [31:0] i_addr, d_addr;
    logic [63:0] i_wdata, i_wmask, d_wdata, d_wmask;
    logic [63:0] i_rdata, d_rdata;
    logic        i_stall, d_stall;
    logic        m_ncs, m_nwe;
    logic [31:0] m_addr;
    logic [63:0] m_wdata, m_wmask, m_rdata;
    logic        m_stall;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    riscv32ima_mem_arb #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .MAX_WAIT(7)) dut (
        .clk(clk), .rst(rst),
        .i_ncs(i_ncs), .i_nwe(i_nwe), .i_addr(i_addr), .i_wdata(i_wdata),
        .i_wmask(i_wmask), .i_rdata(i_rdata), .i_stall(i_stall),
        .d_ncs(d_ncs), .d_nwe(d_nwe), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_rdata(d_rdata), .d_stall(d_stall),
        .m_ncs(m_ncs), .m_nwe(m_nwe), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rdata(m_rdata), .m_stall(m_stall)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge, then let new inputs settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    initial begin
        rst = 1'b1;
        i_ncs = 1'b1; i_nwe = 1'b1; i_addr = '0; i_wdata = '0; i_wmask = '0;
        d_ncs = 1'b1; d_nwe = 1'b1; d_addr = '0; d_wdata = '0; d_wmask = '0;
        m_rdata = '0; m_stall = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_m_ncs",   m_ncs,   1);
        chk("rst_m_nwe",   m_nwe,   1);
        chk("rst_m_addr",  m_addr,  0);
        chk("rst_m_wdata", m_wdata, 0);
        chk("rst_i_stall", i_stall, 0);
        chk("rst_d_stall", d_stall, 0);
        chk("rst_i_rdata", i_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);

`ifdef RISCV32IMA_ARB_RR_EN
        // Both request continuously: d first (last grant resets to i), then alternate.
        tick();
        i_ncs = 1'b0; i_addr = 32'h100;
        d_ncs = 1'b0; d_addr = 32'h200;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk("rr_addr", m_addr, (k % 2 == 0) ? 64'h200 : 64'h100);
            chk("rr_i_stall", i_stall, (k % 2 == 0) ? 64'd1 : 64'd0);
            tick();
        end
        i_ncs = 1'b1; d_ncs = 1'b1;
        settle();
        chk("rr_idle_ncs", m_ncs, 1);
`else
        // Lone fetch read.
        tick();
        i_ncs = 1'b0; i_nwe = 1'b1; i_addr = 32'h100;
        settle();
        chk("t1_m_addr",  m_addr,  64'h100);
        chk("t1_m_ncs",   m_ncs,   0);
        chk("t1_i_stall", i_stall, 0);
        tick();
        i_ncs = 1'b1;
        m_rdata = 64'hDEADBEEF_00000001;
        settle();
        chk("t1_i_rdata", i_rdata, 64'hDEADBEEF_00000001);
        chk("t1_d_rdata", d_rdata, 0);
        chk("t1_m_ncs",   m_ncs,   1);

        // Simultaneous fetch read and data write: data first.
        tick();
        i_ncs = 1'b0; i_addr = 32'h100;
        d_ncs = 1'b0; d_nwe = 1'b0; d_addr = 32'h2000;
        d_wdata = 64'h55; d_wmask = 64'hFF;
        settle();
        chk("t2_m_addr",  m_addr,  64'h2000);
        chk("t2_m_nwe",   m_nwe,   0);
        chk("t2_m_wdata", m_wdata, 64'h55);
        chk("t2_m_wmask", m_wmask, 64'hFF);
        chk("t2_i_stall", i_stall, 1);
        chk("t2_d_stall", d_stall, 0);
        tick();
        d_ncs = 1'b1; d_nwe = 1'b1; d_wdata = '0; d_wmask = '0;
        m_rdata = 64'h1111;
        settle();
        chk("t2_i_gnt_addr", m_addr,  64'h100);
        chk("t2_i_gnt_nwe",  m_nwe,   1);
        chk("t2_i_stall2",   i_stall, 0);
        chk("t2_wr_no_rsp",  d_rdata, 0);
        chk("t2_i_no_rsp",   i_rdata, 0);
        tick();
        i_ncs = 1'b1;
        settle();
        chk("t2_i_rdata", i_rdata, 64'h1111);

        // Starvation bound: d wins 7 times, i forced on the 8th cycle.
        tick();
        i_ncs = 1'b0; i_addr = 32'h300;
        d_ncs = 1'b0; d_nwe = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            d_addr = 32'h4000 + k;
            m_rdata = 64'hA000 + k;
            settle();
            chk("t3_d_addr",  m_addr,  64'h4000 + k);
            chk("t3_i_stall", i_stall, 1);
            if (k > 1) chk("t3_d_rdata", d_rdata, 64'hA000 + k);
            tick();
        end
        d_addr = 32'h4008;
        m_rdata = 64'hA008;
        settle();
        chk("t3_forced_i", m_addr,  64'h300);
        chk("t3_i_stall8", i_stall, 0);
        chk("t3_d_stall8", d_stall, 1);
        chk("t3_d_rdata7", d_rdata, 64'hA008);
        tick();
        i_addr = 32'h304;
        m_rdata = 64'hB000;
        settle();
        chk("t3_cnt_clr_d", m_addr,  64'h4008);
        chk("t3_cnt_clr_i", i_stall, 1);
        chk("t3_i_rdata",   i_rdata, 64'hB000);
        tick();
        i_ncs = 1'b1; d_ncs = 1'b1;
        tick();

        // Data held through three stalled cycles while fetch waits.
        d_ncs = 1'b0; d_addr = 32'h5000;
        i_ncs = 1'b0; i_addr = 32'h600;
        m_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            settle();
            chk("t4_hold_addr", m_addr,  64'h5000);
            chk("t4_i_stall",   i_stall, 1);
            chk("t4_d_stall",   d_stall, 1);
            tick();
        end
        m_stall = 1'b0;
        settle();
        chk("t4_acc_addr",  m_addr,  64'h5000);
        chk("t4_d_stall_0", d_stall, 0);
        chk("t4_i_stall_1", i_stall, 1);
        tick();
        d_ncs = 1'b1;
        m_rdata = 64'hC0DE;
        settle();
        chk("t4_i_gnt",   m_addr,  64'h600);
        chk("t4_i_stall", i_stall, 0);
        chk("t4_d_rdata", d_rdata, 64'hC0DE);
        tick();
        i_ncs = 1'b1;
        tick();

        // Fetch held in HOLD_I, data arrives, then reset mid-hold.
        i_ncs = 1'b0; i_addr = 32'h700;
        m_stall = 1'b1;
        settle();
        chk("t5_i_addr",  m_addr,  64'h700);
        chk("t5_i_stall", i_stall, 1);
        tick();
        d_ncs = 1'b0; d_addr = 32'h8000;
        settle();
        chk("t5_hold_i_addr", m_addr,  64'h700);
        chk("t5_hold_d_stall", d_stall, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_stall = 1'b0;
        settle();
        chk("t5_post_rst_addr",  m_addr,  64'h8000);
        chk("t5_post_rst_istl",  i_stall, 1);
        chk("t5_post_rst_dstl",  d_stall, 0);
        tick();
        d_ncs = 1'b1;
        settle();
        chk("t5_i_after", m_addr, 64'h700);
        tick();
        i_ncs = 1'b1;
        tick();

        // Reset discards a read accepted in the reset cycle.
        d_ncs = 1'b0; d_addr = 32'h9000;
        tick();
        d_ncs = 1'b1;
        i_ncs = 1'b0; i_addr = 32'h900;
        m_rdata = 64'hABCD;
        rst = 1'b1;
        settle();
        chk("t6_pre_rst_d_rdata", d_rdata, 64'hABCD);
        tick();
        rst = 1'b0;
        i_ncs = 1'b1;
        m_rdata = 64'hEEEE;
        settle();
        chk("t6_m_ncs",   m_ncs,   1);
        chk("t6_m_nwe",   m_nwe,   1);
        chk("t6_m_addr",  m_addr,  0);
        chk("t6_i_rdata", i_rdata, 0);
        chk("t6_d_rdata", d_rdata, 0);
        chk("t6_i_stall", i_stall, 0);
        chk("t6_d_stall", d_stall, 0);
`endif

        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
